// File: rtl/knn_point_feeder.sv
// Initiator for the KNN sorter: streams a locally stored point table to the sorter,
// then reads the K ranked neighbour indices back and holds them for the CPU.
module knn_point_feeder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6,
    parameter int K      = 4,
    parameter int IDX_W  = 8,
    parameter int GAP    = 4,
    localparam int SEL_W = (K > 1) ? $clog2(K) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_x,
    input  logic [DATA_W-1:0]   wr_y,
    input  logic [ADDR_W:0]     num_points,
    input  logic [DATA_W-1:0]   test_x,
    input  logic [DATA_W-1:0]   test_y,
    input  logic                start,
    output logic                sorter_rst,
    output logic [DATA_W-1:0]   DATA_X1,
    output logic [DATA_W-1:0]   DATA_Y1,
    output logic [DATA_W-1:0]   DATA_X2,
    output logic [DATA_W-1:0]   DATA_Y2,
    output logic                ready,
    input  logic                DONE,
    output logic [SEL_W-1:0]    SEL,
    input  logic [IDX_W-1:0]    DATA_OUT,
    input  logic [SEL_W-1:0]    res_sel,
    output logic [IDX_W-1:0]    res_idx,
    output logic                busy,
    output logic                done
);

    localparam int N_MAX = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam int GAP_W = $clog2(GAP + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SEND,
        ST_GAP,
        ST_WAIT_DONE,
        ST_READ,
        ST_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                sorter_rst_q, sorter_rst_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [DATA_W-1:0]   x1_q, x1_d;
    logic [DATA_W-1:0]   y1_q, y1_d;
    logic [CNT_W-1:0]    count_in;
    logic                load_send;
    logic                cap_en;

    // Point table: X in the upper half, Y in the lower half of each word.
    logic [2*DATA_W-1:0] mem [N_MAX];
    logic [2*DATA_W-1:0] rd_q;

    assign count_in = (num_points > CNT_W'(N_MAX)) ? CNT_W'(N_MAX) : num_points;

    always_ff @(posedge clk) begin
        if (wr_en && !busy_q) begin
            mem[wr_addr] <= {wr_x, wr_y};
        end
    end

    // The read register doubles as the DATA_X2/DATA_Y2 hold register between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else if (load_send) begin
            rd_q <= mem[ptr_q[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            sorter_rst_q <= 1'b0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            sel_q        <= '0;
            ptr_q        <= '0;
            count_q      <= '0;
            gap_cnt_q    <= '0;
            x1_q         <= '0;
            y1_q         <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            sorter_rst_q <= sorter_rst_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            sel_q        <= sel_d;
            ptr_q        <= ptr_d;
            count_q      <= count_d;
            gap_cnt_q    <= gap_cnt_d;
            x1_q         <= x1_d;
            y1_q         <= y1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        sorter_rst_d = 1'b0;
        ready_d      = 1'b0;
        done_d       = 1'b0;
        sel_d        = sel_q;
        ptr_d        = ptr_q;
        count_d      = count_q;
        gap_cnt_d    = gap_cnt_q;
        x1_d         = x1_q;
        y1_d         = y1_q;
        load_send    = 1'b0;
        cap_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x1_d         = test_x;
                    y1_d         = test_y;
                    count_d      = count_in;
                    busy_d       = 1'b1;
                    sorter_rst_d = 1'b1;
                    ptr_d        = '0;
                    state_d      = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (count_q == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    load_send = 1'b1;
                    ready_d   = 1'b1;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                ptr_d     = ptr_q + CNT_W'(1);
                gap_cnt_d = GAP_W'(GAP - 1);
                state_d   = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    if (ptr_q < count_q) begin
                        load_send = 1'b1;
                        ready_d   = 1'b1;
                        state_d   = ST_SEND;
                    end else begin
                        state_d = ST_WAIT_DONE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (DONE) begin
                    sel_d   = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                cap_en = 1'b1;
                if (sel_q == SEL_W'(K - 1)) begin
                    sel_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    sel_d = sel_q + SEL_W'(1);
                end
            end
            ST_FINISH: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    logic [IDX_W-1:0] res_arr [K];

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_res
            logic [IDX_W-1:0] res_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    res_q <= '0;
                end else if (cap_en && sel_q == SEL_W'(gi)) begin
                    res_q <= DATA_OUT;
                end
            end
            assign res_arr[gi] = res_q;
        end
    endgenerate

    assign res_idx    = res_arr[res_sel];
    assign sorter_rst = sorter_rst_q;
    assign ready      = ready_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign SEL        = sel_q;
    assign DATA_X1    = x1_q;
    assign DATA_Y1    = y1_q;
    assign DATA_X2    = rd_q[2*DATA_W-1:DATA_W];
    assign DATA_Y2    = rd_q[DATA_W-1:0];

endmodule
